// File: rtl/capture_bram_arbiter.sv
// Arbitrates one BRAM port between capture writes (queued, prioritised) and host reads (req/ack).
// Optional drop statistics counter enabled by defining CAP_ARB_STATS_EN.
`timescale 1ns/1ps

module capture_bram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_ack,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  input  logic              clear_ovf,
  output logic              overflow,
  output logic              busy
`ifdef CAP_ARB_STATS_EN
  ,
  output logic [15:0]       stat_drop_cnt
`endif
);

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_WRITE = 2'd1;
  localparam logic [1:0] GNT_READ  = 2'd2;

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0]   STARVE_ONE = SW'(1);

  logic [ADDR_W-1:0] q_addr [2];
  logic [DATA_W-1:0] q_data [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [SW-1:0]     starve;
  logic [RD_LAT-1:0] tok;

  logic       cap_req;
  logic       starve_hit;
  logic       deq;
  logic       drop;
  logic       enq;
  logic [1:0] gnt;

  assign cap_req    = cap_en & cap_we;
  assign starve_hit = host_rd_req && (starve == STARVE_TOP);

  // The decision uses only registered state plus the held host request, so an
  // arriving capture cannot displace a read in the cycle it arrives.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt = GNT_IDLE;
    if ((count != 2'd0) && !starve_hit)
      gnt = GNT_WRITE;
    else if (host_rd_req && !host_rd_ack)
      gnt = GNT_READ;
  end

  assign deq  = (gnt == GNT_WRITE);
  assign drop = cap_req && (count == 2'd2) && !deq;
  assign enq  = cap_req && !drop;

  // NOTE: queue storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= cap_addr;
      q_data[wr_ptr] <= cap_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (!host_rd_req || (gnt == GNT_READ)) begin
      starve <= '0;
    end else if ((gnt == GNT_WRITE) && (starve != STARVE_TOP)) begin
      starve <= starve + STARVE_ONE;
    end
  end

  // BRAM port and ack are registered; address and data hold while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_en     <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      host_rd_ack <= 1'b0;
    end else begin
      bram_en     <= (gnt != GNT_IDLE);
      bram_we     <= (gnt == GNT_WRITE);
      host_rd_ack <= (gnt == GNT_READ);
      if (gnt == GNT_WRITE) begin
        bram_addr <= q_addr[rd_ptr];
        bram_din  <= q_data[rd_ptr];
      end else if (gnt == GNT_READ) begin
        bram_addr <= host_rd_addr;
      end
    end
  end

  // One token per issued read travels RD_LAT stages to line up with bram_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      tok <= '0;
    end else begin
      tok[0] <= host_rd_ack;
      for (int i = 1; i < RD_LAT; i++) tok[i] <= tok[i-1];
    end
  end

  assign host_rd_valid = tok[RD_LAT-1];
  assign host_rd_data  = host_rd_valid ? bram_dout : '0;
  assign busy          = (count != 2'd0) | host_rd_ack | (|tok);

  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef CAP_ARB_STATS_EN
  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_drop_cnt <= 16'd0;
    end else if (drop) begin
      if (clear_ovf)                     stat_drop_cnt <= 16'd1;
      else if (stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end else if (clear_ovf) begin
      stat_drop_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_capture_bram_arbiter.sv
// Directed bench for capture_bram_arbiter with a behavioural BRAM (RD_LAT=2, STARVE_MAX=8).
`timescale 1ns/1ps

module tb_capture_bram_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cap_en = 1'b0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_data = '0;
  logic          host_rd_req = 1'b0;
  logic [AW-1:0] host_rd_addr = '0;
  logic          host_rd_ack;
  logic          host_rd_valid;
  logic [DW-1:0] host_rd_data;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;
  logic          clear_ovf = 1'b0;
  logic          overflow;
  logic          busy;
`ifdef CAP_ARB_STATS_EN
  logic [15:0]   stat_drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  capture_bram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset),
    .cap_en(cap_en), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_ack(host_rd_ack), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .clear_ovf(clear_ovf), .overflow(overflow), .busy(busy)
`ifdef CAP_ARB_STATS_EN
    , .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: unwritten locations read as addr[7:0]^8'h3C, two-cycle read latency.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rd_s1 = '0;

  function automatic logic [DW-1:0] fetch(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] = bram_din;
    if (bram_en && !bram_we) rd_s1 <= fetch(bram_addr);
    bram_dout <= rd_s1;
  end

  // Port activity log: 1 = write, 2 = read issue.
  int            ev_log [$];
  logic [AW-1:0] wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];
  logic [DW-1:0] valid_log [$];

  always @(negedge clk) begin
    if (bram_en && bram_we) begin
      ev_log.push_back(1);
      wr_addr_log.push_back(bram_addr);
      wr_data_log.push_back(bram_din);
    end else if (bram_en) begin
      ev_log.push_back(2);
    end
    if (host_rd_valid) valid_log.push_back(host_rd_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures every cycle for 19 cycles; host requests from cycle 1 and
  // re-requests after each ack until two reads have issued.
  task automatic run_starve(input logic [AW-1:0] base, input logic [AW-1:0] rbase,
                            input bit clr_on_drop, input bit ovf_prior);
    int ev0 = ev_log.size();
    int wr0 = wr_addr_log.size();
    int vl0 = valid_log.size();
    int acks = 0;
    int nw1 = 0, nw2 = 0, nrd = 0, nwr = 0, bad = 0;
    for (int i = 0; i < 19; i++) begin
      cap_en       = 1'b1;
      cap_we       = 1'b1;
      cap_addr     = base + AW'(i);
      cap_data     = DW'(32'h40 + i);
      host_rd_req  = (i >= 1) && (acks < 2);
      host_rd_addr = rbase + AW'(acks);
      clear_ovf    = clr_on_drop && (i == 18);
      tick();
      if (host_rd_ack) acks++;
      if (i == 17) check("ovf_before_drop", 32'(overflow), 32'(ovf_prior));
    end
    cap_en = 1'b0; cap_we = 1'b0; host_rd_req = 1'b0; clear_ovf = 1'b0;
    check("starve_acks", 32'(acks), 2);
    check("ovf_set_on_drop", 32'(overflow), 1);
`ifdef CAP_ARB_STATS_EN
    check("stat_after_drop", 32'(stat_drop_cnt), 1);
`endif
    clear_ovf = clr_on_drop;
    tick();
    clear_ovf = 1'b0;
    check("ovf_after_clear", 32'(overflow), clr_on_drop ? 0 : 1);
`ifdef CAP_ARB_STATS_EN
    check("stat_after_clear", 32'(stat_drop_cnt), clr_on_drop ? 0 : 1);
`endif
    repeat (6) tick();
    for (int k = ev0; k < ev_log.size(); k++) begin
      if (ev_log[k] == 2) nrd++;
      else begin
        nwr++;
        if (nrd == 0) nw1++;
        else if (nrd == 1) nw2++;
      end
    end
    check("starve_writes_first", 32'(nw1), 8);
    check("starve_writes_second", 32'(nw2), 8);
    check("starve_reads", 32'(nrd), 2);
    check("starve_total_writes", 32'(nwr), 18);
    for (int k = 0; k < 18 && (wr0 + k) < wr_addr_log.size(); k++)
      if (wr_addr_log[wr0+k] != base + AW'(k) || wr_data_log[wr0+k] != DW'(32'h40 + k)) bad++;
    check("starve_write_order", 32'(bad), 0);
    check("starve_valids", 32'(valid_log.size() - vl0), 2);
    if (valid_log.size() >= vl0 + 2) begin
      check("starve_rd0_data", 32'(valid_log[vl0]), 32'(rbase[7:0] ^ 8'h3C));
      check("starve_rd1_data", 32'(valid_log[vl0+1]), 32'((rbase[7:0] + 8'd1) ^ 8'h3C));
    end
    check("starve_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vl0, ev0, wr0, rd_idx, bad;

    // Reset state
    repeat (3) tick();
    check("rst_bram_en", 32'(bram_en), 0);
    check("rst_bram_we", 32'(bram_we), 0);
    check("rst_bram_addr", 32'(bram_addr), 0);
    check("rst_ack", 32'(host_rd_ack), 0);
    check("rst_valid", 32'(host_rd_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // Single capture write with idle host: appears two cycles after the request
    cap_en = 1'b1; cap_we = 1'b1; cap_addr = 18'h00005; cap_data = 8'hA5;
    tick();
    cap_en = 1'b0; cap_we = 1'b0;
    check("wr1_not_yet", 32'(bram_en), 0);
    check("wr1_busy", 32'(busy), 1);
    tick();
    check("wr1_en", 32'(bram_en), 1);
    check("wr1_we", 32'(bram_we), 1);
    check("wr1_addr", 32'(bram_addr), 'h00005);
    check("wr1_din", 32'(bram_din), 'hA5);
    tick();
    check("wr1_done_en", 32'(bram_en), 0);
    check("wr1_done_busy", 32'(busy), 0);

    // Host read of the top address
    host_rd_req = 1'b1; host_rd_addr = 18'h3FFFF;
    tick();
    check("rd_ack", 32'(host_rd_ack), 1);
    check("rd_en", 32'(bram_en), 1);
    check("rd_we", 32'(bram_we), 0);
    check("rd_addr", 32'(bram_addr), 'h3FFFF);
    host_rd_req = 1'b0;
    tick();
    check("rd_ack_pulse", 32'(host_rd_ack), 0);
    check("rd_valid_early", 32'(host_rd_valid), 0);
    check("rd_busy", 32'(busy), 1);
    tick();
    check("rd_valid", 32'(host_rd_valid), 1);
    check("rd_data", 32'(host_rd_data), 'hC3);
    tick();
    check("rd_valid_pulse", 32'(host_rd_valid), 0);

    // Reset one cycle after ack discards the in-flight read
    vl0 = valid_log.size();
    host_rd_req = 1'b1; host_rd_addr = 18'h00010;
    tick();
    check("rstrd_ack", 32'(host_rd_ack), 1);
    host_rd_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstrd_valid", 32'(host_rd_valid), 0);
    check("rstrd_data", 32'(host_rd_data), 0);
    check("rstrd_en", 32'(bram_en), 0);
    check("rstrd_addr", 32'(bram_addr), 0);
    check("rstrd_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("rstrd_no_valid", 32'(valid_log.size() - vl0), 0);

    // Starvation limit with a drop; then a clear colliding with a second drop
    run_starve(18'h00100, 18'h00200, 1'b0, 1'b0);
    run_starve(18'h00300, 18'h00210, 1'b1, 1'b1);

    // Alternate-cycle captures (odd cycles: en without we) with back-to-back host reads
    ev0 = ev_log.size(); wr0 = wr_addr_log.size(); vl0 = valid_log.size();
    rd_idx = 0;
    for (int t = 0; t < 40; t++) begin
      cap_en       = (t < 32);
      cap_we       = (t % 2 == 0) && (t < 32);
      cap_addr     = AW'(32'h500 + t / 2);
      cap_data     = DW'(32'h80 + t / 2);
      host_rd_req  = (rd_idx < 8);
      host_rd_addr = AW'(32'h100 + rd_idx);
      tick();
      if (host_rd_ack) rd_idx++;
    end
    cap_en = 1'b0; cap_we = 1'b0; host_rd_req = 1'b0;
    repeat (6) tick();
    check("alt_reads_issued", 32'(rd_idx), 8);
    if (ev_log.size() >= ev0 + 2) begin
      check("alt_first_is_read", 32'(ev_log[ev0]), 2);
      check("alt_then_write", 32'(ev_log[ev0+1]), 1);
    end
    check("alt_nwrites", 32'(wr_addr_log.size() - wr0), 16);
    bad = 0;
    for (int k = 0; k < 16 && (wr0 + k) < wr_addr_log.size(); k++)
      if (wr_addr_log[wr0+k] != AW'(32'h500 + k) || wr_data_log[wr0+k] != DW'(32'h80 + k)) bad++;
    check("alt_write_order", 32'(bad), 0);
    check("alt_nvalids", 32'(valid_log.size() - vl0), 8);
    bad = 0;
    for (int k = 0; k < 8 && (vl0 + k) < valid_log.size(); k++)
      if (valid_log[vl0+k] != DW'(32'h40 + k)) bad++;
    check("alt_read_data", 32'(bad), 0);
    check("alt_no_overflow", 32'(overflow), 0);
    check("alt_idle_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
